// File: rtl/key_sw_pio_pkg.sv
// Shared register map and reset constants for the KEY/SW input port.
package key_sw_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EDGESEL = 2'd3;

    // KEY inputs are active-low, so an idle board reads all ones.
    localparam logic [31:0] STABLE_RST = '1;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchronizer then optional debounce (KEY_SW_PIO_DEBOUNCE_EN).
// dout is the next-cycle stable value; 2 + DEBOUNCE_CYCLES cycles pin-to-stable, no backpressure.
module pio_debounce_bit
    import key_sw_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= STABLE_RST[0];
            sync_q <= STABLE_RST[0];
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

`ifdef KEY_SW_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // Counter only runs while sync disagrees; any agreeing cycle restarts it.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= STABLE_RST[0];
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign dout = stable_d;
`else
    assign dout = sync_q;
`endif

endmodule

// File: rtl/key_sw_pio_in.sv
// Avalon-MM input PIO for KEY/SW: DATA, IRQMASK, EDGECAP (W1C), EDGESEL, level irq; debounce via KEY_SW_PIO_DEBOUNCE_EN.
// Read latency 1 cycle; writes land on the write edge; DATA and EDGECAP update on the same edge.
// No backpressure: the slave accepts every read and write in the cycle it is presented.
module key_sw_pio_in
    import key_sw_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 14,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in
);

    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgesel_d;
    logic [WIDTH-1:0] edgesel_q;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      readdata_d;
    logic [31:0]      readdata_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (pio_in[i]),
            .dout    (stable_d[i])
        );
    end

    // Sub-modules hand over the next stable value, so events are seen on the edge stable moves.
    assign edge_evt = ( edgesel_q &  stable_d & ~stable_q)
                    | (~edgesel_q & ~stable_d &  stable_q);

    assign w1c = (avs_write && avs_address == ADDR_EDGECAP) ? avs_writedata[WIDTH-1:0] : '0;

    always_comb begin
        irqmask_d = irqmask_q;
        edgesel_d = edgesel_q;
        if (avs_write && avs_address == ADDR_IRQMASK) begin
            irqmask_d = avs_writedata[WIDTH-1:0];
        end
        if (avs_write && avs_address == ADDR_EDGESEL) begin
            edgesel_d = avs_writedata[WIDTH-1:0];
        end
        // A fresh event beats a simultaneous clear of the same bit.
        edgecap_d = (edgecap_q & ~w1c) | edge_evt;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA:    readdata_d = 32'(stable_q);
                ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
                ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
                default:      readdata_d = 32'(edgesel_q);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q   <= STABLE_RST[WIDTH-1:0];
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            edgesel_q  <= '0;
            readdata_q <= '0;
        end else begin
            stable_q   <= stable_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            edgesel_q  <= edgesel_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_key_sw_pio_in.sv
// Directed test-plan steps plus a randomized phase, all checked against a behavioural register/debounce model.
module tb_key_sw_pio_in;

    localparam int W  = 14;
    localparam int DC = 8;
`ifdef KEY_SW_PIO_DEBOUNCE_EN
    localparam bit          DEB        = 1'b1;
    localparam int          EVT_EDGE   = DC + 2;
    localparam logic [31:0] BOUNCE_CAP = 32'h1;
    localparam logic [31:0] BOUNCE_LOW = 32'd0;
`else
    localparam bit          DEB        = 1'b0;
    localparam int          EVT_EDGE   = 3;
    localparam logic [31:0] BOUNCE_CAP = 32'h21;
    localparam logic [31:0] BOUNCE_LOW = 32'd1;
`endif
    localparam int RD_LAT = EVT_EDGE + 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   avs_address;
    logic         avs_read;
    logic         avs_write;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         irq;
    logic [W-1:0] pio_in;

    int checks = 0;
    int errors = 0;

    key_sw_pio_in #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .pio_in        (pio_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: pins reach the "seen" value two cycles late; a bit adopts
    // the seen value once it has disagreed with the current value for DC cycles in a row.
    logic [W-1:0] m_pin1, m_seen, m_stable, m_mask, m_cap, m_sel;
    int           m_run [W];
    logic [31:0]  m_rd;

    task automatic model_reset();
        m_pin1   = '1;
        m_seen   = '1;
        m_stable = '1;
        m_mask   = '0;
        m_cap    = '0;
        m_sel    = '0;
        m_rd     = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_cap);
            default: return 32'(m_sel);
        endcase
    endfunction

    function automatic logic m_irq();
        return |(m_cap & m_mask);
    endfunction

    task automatic model_edge();
        logic [W-1:0] nxt;
        logic [W-1:0] ev;
        nxt = m_stable;
        for (int i = 0; i < W; i++) begin
            if (!DEB) begin
                nxt[i] = m_seen[i];
            end else if (m_seen[i] != m_stable[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DC) begin
                    nxt[i]   = m_seen[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        // A change is captured when the new level matches the selected edge direction.
        ev = '0;
        for (int i = 0; i < W; i++)
            if (nxt[i] != m_stable[i] && nxt[i] == m_sel[i]) ev[i] = 1'b1;
        if (avs_read) m_rd = m_reg(avs_address);
        if (avs_write) begin
            if (avs_address == 2'd1) m_mask = avs_writedata[W-1:0];
            if (avs_address == 2'd3) m_sel  = avs_writedata[W-1:0];
            if (avs_address == 2'd2) m_cap  = m_cap & ~avs_writedata[W-1:0];
        end
        m_cap    = m_cap | ev;
        m_stable = nxt;
        m_seen   = m_pin1;
        m_pin1   = pio_in;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: DUT and model advance on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        check("rdata", avs_readdata, m_rd);
        check("irq", 32'(irq), 32'(m_irq()));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic bus_read(input logic [1:0] a);
        avs_read    = 1'b1;
        avs_address = a;
        cycle();
        avs_read    = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_write     = 1'b1;
        avs_address   = a;
        avs_writedata = d;
        cycle();
        avs_write     = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_rdata", avs_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        idle(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int first;
        int seen_low;
        int hold;
        int op;
        logic [31:0] first_val;

        reset_n       = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        pio_in        = '1;
        model_reset();
        @(negedge clk);

        // Reset state and idle DATA.
        apply_reset();
        idle(3);
        bus_read(2'd0);
        check("data_after_reset", avs_readdata, 32'h0000_3FFF);
        check("irq_after_reset", 32'(irq), 32'd0);

        // Falling KEY0: latency of DATA bit 0, then EDGECAP.
        pio_in[0]   = 1'b0;
        avs_read    = 1'b1;
        avs_address = 2'd0;
        first = -1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (first < 0 && avs_readdata[0] == 1'b0) first = k;
        end
        avs_read = 1'b0;
        check("key0_latency", 32'(first), 32'(RD_LAT));
        bus_read(2'd2);
        check("edgecap_key0", avs_readdata, 32'h1);
        check("irq_masked", 32'(irq), 32'd0);

        // Bounce on SW bit 5.
        seen_low    = 0;
        avs_read    = 1'b1;
        avs_address = 2'd0;
        for (int c = 0; c < 50; c++) begin
            pio_in[5] = ((c / 3) % 2) != 0;
            cycle();
            if (avs_readdata[5] == 1'b0) seen_low = 1;
        end
        pio_in[5] = 1'b1;
        idle(12);
        avs_read = 1'b0;
        check("bounce_data_low", 32'(seen_low), BOUNCE_LOW);
        bus_read(2'd2);
        check("bounce_edgecap", avs_readdata, BOUNCE_CAP);
        bus_write(2'd2, 32'h3FFF);
        bus_read(2'd2);
        check("edgecap_cleared", avs_readdata, 32'd0);

        // Event colliding with W1C on bit 0.
        bus_write(2'd1, 32'h1);
        pio_in[0] = 1'b1;
        idle(14);
        check("irq_rise_ignored", 32'(irq), 32'd0);
        pio_in[0] = 1'b0;
        for (int k = 1; k <= EVT_EDGE; k++) begin
            if (k == EVT_EDGE) begin
                avs_write     = 1'b1;
                avs_address   = 2'd2;
                avs_writedata = 32'h1;
            end
            cycle();
        end
        avs_write = 1'b0;
        check("irq_event_wins", 32'(irq), 32'd1);
        bus_read(2'd2);
        check("edgecap_event_wins", avs_readdata, 32'h1);
        bus_write(2'd2, 32'h1);
        check("irq_after_w1c", 32'(irq), 32'd0);

        // Rising-edge selection on SW bit 4.
        bus_write(2'd3, 32'h10);
        pio_in[4] = 1'b0;
        idle(14);
        bus_read(2'd2);
        check("sel_fall_ignored", avs_readdata, 32'd0);
        pio_in[4] = 1'b1;
        idle(14);
        bus_read(2'd2);
        check("sel_rise_captured", avs_readdata, 32'h10);
        bus_write(2'd2, 32'h10);
        pio_in[4] = 1'b0;
        idle(14);
        bus_read(2'd2);
        check("sel_fall_again", avs_readdata, 32'd0);
        bus_read(2'd3);
        check("edgesel_readback", avs_readdata, 32'h10);

        // Reset while bit 2 is mid-count.
        pio_in = '1;
        idle(14);
        pio_in[2] = 1'b0;
        idle(7);
        apply_reset();
        avs_read    = 1'b1;
        avs_address = 2'd0;
        first     = -1;
        first_val = '0;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (k == 1) first_val = avs_readdata;
            if (first < 0 && avs_readdata[2] == 1'b0) first = k;
        end
        avs_read = 1'b0;
        check("data_after_midreset", first_val, 32'h0000_3FFF);
        check("bit2_latency_after_reset", 32'(first), 32'(RD_LAT));

        // Randomized pins and bus traffic.
        hold = 1;
        for (int c = 0; c < 500; c++) begin
            hold--;
            if (hold == 0) begin
                pio_in[$urandom_range(0, W - 1)] ^= 1'b1;
                hold = $urandom_range(1, 14);
            end
            op = $urandom_range(0, 3);
            avs_read      = (op == 1 || op == 2);
            avs_write     = (op == 3);
            avs_address   = 2'($urandom_range(0, 3));
            avs_writedata = $urandom();
            cycle();
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
